// File: rtl/ay38500_pkg.sv
// Shared types for the AY-3-8500 paddle emulation: input modes, pot FSM states,
// digital direction, and the per-mode capture value selection.
package ay38500_pkg;

    typedef enum logic [1:0] {
        PAD_DIGITAL = 2'd0,
        PAD_Y       = 2'd1,
        PAD_X       = 2'd2,
        PAD_XINV    = 2'd3
    } paddle_mode_t;

    typedef enum logic {
        DONE  = 1'b0,
        COUNT = 1'b1
    } pot_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    // Signed stick values are offset-binary converted so that centre maps to 128.
    function automatic logic [7:0] capture_sel(input paddle_mode_t m,
                                               input logic [15:0] a,
                                               input logic [7:0] p);
        logic [7:0] v;
        case (m)
            PAD_Y:    v = {~a[15], a[14:8]};
            PAD_X:    v = {~a[7], a[6:0]};
            PAD_XINV: v = {a[7], ~a[6:0]};
            default:  v = p;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/paddle_pot_emu_rise_edge.sv
// Rising-edge detector: one delay register plus an AND, all in the clk_sys domain.
module rise_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk_sys) begin
        if (reset) sig_d <= 1'b0;
        else       sig_d <= sig;
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/paddle_pot_emu.sv
// One AY-3-8500 paddle pot/capacitor emulator: captures a per-frame line delay on
// vsync and counts it down on hsync; pot_out is high once the cap has discharged.
module paddle_pot_emu
    import ay38500_pkg::*;
#(
    parameter int POS_RESET    = 128,
    parameter int STEP_SLOW    = 5,
    parameter int STEP_FAST    = 8,
    parameter int ACCEL_FRAMES = 8,
    parameter int ACCEL_ADD    = 4,
    parameter int LINE_OFFSET  = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic [1:0]  mode,
    input  logic        speed_fast,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [15:0] analog,
    output logic        pot_out,
    output logic        fired,
    output logic [7:0]  pos
);

    logic         hs_rise, vs_rise;
    logic [8:0]   cap, cap_next;
    logic         fired_next;
    pot_state_t   state, state_next;
    logic [3:0]   hold_cnt, hold_next;
    dir_t         hold_dir, dir;
    logic [7:0]   pos_next;
    logic [8:0]   step, pos_sum, pos_diff;
    paddle_mode_t pmode;

    assign pmode = paddle_mode_t'(mode);

    rise_edge u_hs_edge (.clk_sys(clk_sys), .reset(reset), .sig(hs), .rise(hs_rise));
    rise_edge u_vs_edge (.clk_sys(clk_sys), .reset(reset), .sig(vs), .rise(vs_rise));

    // A vsync capture takes priority over a coincident hsync decrement.
    always_comb begin
        cap_next   = cap;
        fired_next = 1'b0;
        if (vs_rise) begin
            cap_next = {1'b0, capture_sel(pmode, analog, pos)} + 9'(LINE_OFFSET);
        end else if (hs_rise && cap != 9'd0) begin
            cap_next   = cap - 9'd1;
            fired_next = (cap == 9'd1);
        end
    end

    always_comb begin
        if (btn_down)    dir = DOWN;
        else if (btn_up) dir = UP;
        else             dir = NONE;
    end

    always_comb begin
        step = 9'(speed_fast ? STEP_FAST : STEP_SLOW)
             + ((hold_cnt >= 4'(ACCEL_FRAMES)) ? 9'(ACCEL_ADD) : 9'd0);
        pos_sum  = {1'b0, pos} + step;
        pos_diff = {1'b0, pos} - step;
        case (dir)
            UP:      pos_next = ({1'b0, pos} < step) ? 8'd0 : pos_diff[7:0];
            DOWN:    pos_next = (pos_sum > 9'd255) ? 8'd255 : pos_sum[7:0];
            default: pos_next = pos;
        endcase
        if (dir == hold_dir && dir != NONE)
            hold_next = (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
        else
            hold_next = 4'd0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cap      <= 9'd0;
            fired    <= 1'b0;
            pos      <= 8'(POS_RESET);
            hold_cnt <= 4'd0;
            hold_dir <= NONE;
        end else begin
            cap   <= cap_next;
            fired <= fired_next;
            if (vs_rise && pmode == PAD_DIGITAL) begin
                pos      <= pos_next;
                hold_cnt <= hold_next;
                hold_dir <= dir;
            end
        end
    end

    // FSM: state register / next-state / output; state tracks whether cap is nonzero.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= DONE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = (cap_next != 9'd0) ? COUNT : DONE;
    end

    always_comb begin
        pot_out = (state == DONE);
    end

endmodule

// File: tb/tb_paddle_pot_emu.sv
// Directed bench for paddle_pot_emu: digital movement, saturation, acceleration,
// analog captures, sync collision and mid-count reset.
module tb_paddle_pot_emu;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        speed_fast = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [15:0] analog = 16'h0000;
    logic        pot_out, fired;
    logic [7:0]  pos;

    int checks = 0;
    int errors = 0;

    // Hold counter reads 0 on the first held frame, so +8 applies for 9 frames.
    int acc_exp [15] = '{136, 144, 152, 160, 168, 176, 184, 192, 200,
                         212, 224, 236, 248, 255, 255};

    always #5 clk_sys = ~clk_sys;

    paddle_pot_emu dut (
        .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .mode(mode),
        .speed_fast(speed_fast), .btn_up(btn_up), .btn_down(btn_down),
        .analog(analog), .pot_out(pot_out), .fired(fired), .pos(pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse(output logic f);
        vs = 1'b1;
        @(negedge clk_sys);
        f = fired;
        vs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic hs_pulse(output logic f);
        hs = 1'b1;
        @(negedge clk_sys);
        f = fired;
        hs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic both_pulse();
        hs = 1'b1;
        vs = 1'b1;
        @(negedge clk_sys);
        hs = 1'b0;
        vs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic measure(output int lines, output int fires);
        logic f;
        lines = 0;
        fires = 0;
        while (pot_out !== 1'b1 && lines < 600) begin
            hs_pulse(f);
            lines++;
            if (f === 1'b1) fires++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    initial begin
        logic f;
        int   lines, fires;

        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        check("reset_pos", pos, 128);
        check("reset_pot", pot_out, 1);
        check("reset_fired", fired, 0);
        fires = 0;
        repeat (3) begin
            hs_pulse(f);
            if (f === 1'b1) fires++;
        end
        check("hs_only_pot", pot_out, 1);
        check("hs_only_fires", fires, 0);
        check("hs_only_pos", pos, 128);

        btn_down = 1'b1;
        vs_pulse(f);
        check("dig1_pos", pos, 133);
        check("dig1_pot_low", pot_out, 0);
        measure(lines, fires);
        check("dig1_lines", lines, 128);
        check("dig1_fires", fires, 1);
        vs_pulse(f);
        check("dig2_pos", pos, 138);
        measure(lines, fires);
        check("dig2_lines", lines, 133);
        vs_pulse(f);
        check("dig3_pos", pos, 143);
        measure(lines, fires);
        check("dig3_lines", lines, 138);
        btn_down = 1'b0;

        do_reset();
        for (int i = 0; i < 25; i++) begin
            btn_up = 1'b1;
            vs_pulse(f);
            if (i % 5 == 4) begin
                btn_up = 1'b0;
                vs_pulse(f);
            end
        end
        check("sat_pre_pos", pos, 3);
        btn_up = 1'b1;
        vs_pulse(f);
        check("sat_pos", pos, 0);
        check("sat_cap3_pot", pot_out, 0);
        btn_up = 1'b0;
        vs_pulse(f);
        check("cap0_pot", pot_out, 1);
        check("cap0_fired", f, 0);
        check("cap0_fired_after", fired, 0);

        do_reset();
        speed_fast = 1'b1;
        btn_down = 1'b1;
        for (int k = 0; k < 15; k++) begin
            vs_pulse(f);
            check($sformatf("accel_pos_%0d", k), pos, acc_exp[k]);
        end

        mode = 2'd1;
        analog = 16'h0000;
        vs_pulse(f);
        check("an_y_pos_held", pos, 255);
        measure(lines, fires);
        check("an_y_lines", lines, 128);
        vs_pulse(f);
        repeat (4) hs_pulse(f);
        analog = 16'h8000;
        vs_pulse(f);
        check("an_y80_pot", pot_out, 1);
        check("an_y80_fired", f, 0);
        mode = 2'd3;
        analog = 16'h0000;
        vs_pulse(f);
        measure(lines, fires);
        check("an_xinv_lines", lines, 127);
        mode = 2'd2;
        analog = 16'h0005;
        vs_pulse(f);
        analog = 16'h00FF;
        mode = 2'd1;
        measure(lines, fires);
        check("an_x_midframe_lines", lines, 133);
        check("an_x_fires", fires, 1);

        mode = 2'd2;
        analog = 16'h0085;
        vs_pulse(f);
        hs = 1'b1;
        repeat (4) @(negedge clk_sys);
        hs = 1'b0;
        @(negedge clk_sys);
        measure(lines, fires);
        check("hs_level_lines", lines, 4);

        vs_pulse(f);
        hs_pulse(f);
        hs_pulse(f);
        both_pulse();
        measure(lines, fires);
        check("collision_lines", lines, 5);

        analog = 16'h00A8;
        vs_pulse(f);
        repeat (3) hs_pulse(f);
        check("pre_reset_pot", pot_out, 0);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("midreset_pot", pot_out, 1);
        check("midreset_fired", fired, 0);
        check("midreset_pos", pos, 128);
        fires = 0;
        repeat (40) begin
            hs_pulse(f);
            if (f === 1'b1) fires++;
        end
        check("midreset_no_fire", fires, 0);
        check("midreset_pot_after", pot_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
